// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter slice.
//   state_e   : arbiter FSM encoding (S_IDLE / S_XFER)
//   STALL_W   : width of the per-grant stall watchdog counter
//   gw_of()   : index width for N requesters, never below 1 bit
package uart_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_e;

  localparam int STALL_W = 24;

  function automatic int gw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index (must be < N)
//   found : at least one request is set
//   idx   : first set request at or after ptr, wrapping modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          found,
  output logic [GW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [GW-1:0]  off;
  logic [GW:0]    sum;

  // Rotate so ptr lands on bit 0, then priority-encode the lowest set bit.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = GW'(i);
      end
    end
    // Undo the rotation; explicit wrap keeps non-power-of-2 N correct.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (GW + 1)'(N)) sum = sum - (GW + 1)'(N);
    idx = sum[GW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte path.
//   clk, rst       : clock, synchronous active-high reset
//   req_valid/data/last, req_ready : per-requester byte streams
//   tx_dout, tx_we, tx_full        : write port toward the TX FIFO
//   grant_id       : current packet owner
//   busy           : a packet is granted
//   timeout_pulse  : one-cycle pulse when a stalled packet is aborted
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          N_REQ          = 4,
  parameter int          WORD_WIDTH     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  localparam int         GW             = gw_of(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*WORD_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic [WORD_WIDTH-1:0]       tx_dout,
  output logic                        tx_we,
  input  logic                        tx_full,
  output logic [GW-1:0]               grant_id,
  output logic                        busy,
  output logic                        timeout_pulse
);

  localparam bit                 WD_EN = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [STALL_W-1:0] TO_M1 = STALL_W'(TIMEOUT_CYCLES - 32'd1);

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 timeout_q, timeout_d;

  logic [N_REQ-1:0][WORD_WIDTH-1:0] data_arr;
  logic                 g_valid, g_last;
  logic                 pick_found;
  logic [GW-1:0]        pick_idx;
  logic [GW-1:0]        next_ptr;

  assign data_arr = req_data;
  assign g_valid  = req_valid[grant_q];
  assign g_last   = req_last[grant_q];
  assign next_ptr = (grant_q == GW'(N_REQ - 1)) ? '0 : GW'(grant_q + 1'b1);

  rr_pick #(.N(N_REQ), .GW(GW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    stall_d   = stall_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_XFER;
          grant_d = pick_idx;
          stall_d = '0;
        end
      end
      S_XFER: begin
        if (g_valid) begin
          // Back-pressure with valid data is not a stall: hold the count.
          if (!tx_full) begin
            stall_d = '0;
            if (g_last) begin
              state_d  = S_IDLE;
              rr_ptr_d = next_ptr;
            end
          end
        end else if (WD_EN && stall_q == TO_M1) begin
          // Abort; leftover bytes of this packet will arbitrate as a new one.
          timeout_d = 1'b1;
          state_d   = S_IDLE;
          rr_ptr_d  = next_ptr;
          stall_d   = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    tx_we     = 1'b0;
    tx_dout   = data_arr[grant_q];
    busy      = (state_q == S_XFER);
    if (state_q == S_XFER) begin
      req_ready[grant_q] = ~tx_full;
      tx_we              = g_valid & ~tx_full;
    end
  end

  assign grant_id      = grant_q;
  assign timeout_pulse = timeout_q;

endmodule
